// File: rtl/hram_resp_model_pkg.sv
// Shared definitions for the block-RAM backed HyperRAM responder model.
// State encoding and default burst/latency values.
package hram_resp_model_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAT,
    ST_WR,
    ST_RDA,
    ST_RD
  } hram_st_e;

  localparam int unsigned DEF_BURST = 4;
  localparam int unsigned DEF_LAT   = 6;

endpackage

// File: rtl/hram_resp_model_resp_ram.sv
// Single-port 2^AW x 16 synchronous RAM with registered, read-enabled output.
// The output register holds its value when no read is issued.
module resp_ram #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   din,
  output logic [15:0]   dout
);

  logic [15:0] mem [2**AW];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
    end else if (re) begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/hram_resp_model.sv
// Responder model for the HyperRAM command interface, backed by on-chip RAM.
// Accepts one command at a time; write bursts paced by next_wr, reads returned on mdata.
module hram_resp_model
  import hram_resp_model_pkg::*;
#(
  parameter int unsigned MEM_AW = 10,
  parameter int unsigned BURST  = DEF_BURST,
  parameter int unsigned LAT    = DEF_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rdwr,
  input  logic [23:0] addr,
  input  logic [15:0] wr_data,
  output logic        next_wr,
  output logic [15:0] mdata,
  output logic        mdata_ready,
  output logic        mbusy
);

  localparam int unsigned WW = $clog2(BURST + 1);

  hram_st_e          st_q, st_d;
  logic              rdwr_q, rdwr_d;
  logic [MEM_AW-1:0] base_q, base_d;
  logic [3:0]        lat_q, lat_d;
  logic [WW-1:0]     wi_q, wi_d;

  logic              ram_we, ram_re;
  logic [MEM_AW-1:0] ram_addr;
  logic              unused_addr;

  // Upper address bits alias onto the RAM.
  assign unused_addr = ^addr[23:MEM_AW];
  assign ram_addr    = base_q + MEM_AW'(wi_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= ST_IDLE;
      rdwr_q <= 1'b0;
      base_q <= '0;
      lat_q  <= '0;
      wi_q   <= '0;
    end else begin
      st_q   <= st_d;
      rdwr_q <= rdwr_d;
      base_q <= base_d;
      lat_q  <= lat_d;
      wi_q   <= wi_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    rdwr_d = rdwr_q;
    base_d = base_q;
    lat_d  = lat_q;
    wi_d   = wi_q;
    ram_we = 1'b0;
    ram_re = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (start) begin
          rdwr_d = rdwr;
          base_d = addr[MEM_AW-1:0];
          lat_d  = 4'(LAT);
          wi_d   = '0;
          st_d   = ST_LAT;
        end
      end
      ST_LAT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          st_d = rdwr_q ? ST_RDA : ST_WR;
        end
      end
      ST_WR: begin
        ram_we = 1'b1;
        wi_d   = wi_q + 1'b1;
        if (wi_q == WW'(BURST - 1)) begin
          st_d = ST_IDLE;
        end
      end
      ST_RDA: begin
        ram_re = 1'b1;
        wi_d   = wi_q + 1'b1;
        st_d   = ST_RD;
      end
      ST_RD: begin
        // Prefetch the next word while presenting the current one; stop
        // issuing once all words are fetched so mdata holds the last one.
        if (wi_q == WW'(BURST)) begin
          st_d = ST_IDLE;
        end else begin
          ram_re = 1'b1;
          wi_d   = wi_q + 1'b1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  assign next_wr     = (st_q == ST_WR);
  assign mdata_ready = (st_q == ST_RD);
  assign mbusy       = (st_q != ST_IDLE);

  resp_ram #(
    .AW(MEM_AW)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .din  (wr_data),
    .dout (mdata)
  );

endmodule
